// File: rtl/booth_mult_seq.sv
// booth_mult_seq
//   Iterative radix-2 Booth multiplier. One Booth step per clock; operands are
//   accepted through a valid/ready handshake and the product is offered through
//   a second valid/ready handshake. The signed/unsigned mode is chosen per
//   transaction.
//
//   Both operands are widened to WIDTH+1 bits, with the extra bit holding the
//   sign or zero extension. The multiplier is therefore always a signed
//   (WIDTH+1)-bit value, and WIDTH+1 Booth steps produce the exact product in
//   both modes, including the unsigned maximum and the most-negative signed
//   value.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous reset, active-high
//   in_valid     operands valid
//   in_ready     ready to accept operands (IDLE only)
//   in_signed    1: two's-complement operands, 0: unsigned
//   in_a         multiplicand, WIDTH bits
//   in_b         multiplier, WIDTH bits
//   out_valid    out_product valid
//   out_ready    consumer accepts the result
//   out_product  product, 2*WIDTH bits, held until the next result is written
//   busy         high while computing or presenting a result
module booth_mult_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic                 busy
);

    localparam int EW = WIDTH + 1;           // extended operand width
    localparam int AW = WIDTH + 2;           // accumulator width, never overflows
    localparam int CW = $clog2(WIDTH + 1);   // iteration counter width

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t             state_reg;
    logic [EW-1:0]      m_reg;
    logic [EW-1:0]      q_reg;
    logic [AW-1:0]      a_reg;
    logic               q_m1_reg;
    logic [CW-1:0]      cnt_reg;
    logic [2*WIDTH-1:0] prod_reg;
    logic               in_ready_reg;
    logic               out_valid_reg;
    logic               busy_reg;

    // Operand extension: low bits pass through, the top bit is the sign bit
    // in signed mode and zero in unsigned mode.
    logic [EW-1:0] a_ext;
    logic [EW-1:0] b_ext;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_ext
            assign a_ext[gi] = in_a[gi];
            assign b_ext[gi] = in_b[gi];
        end
    endgenerate
    assign a_ext[WIDTH] = in_signed & in_a[WIDTH-1];
    assign b_ext[WIDTH] = in_signed & in_b[WIDTH-1];

    // One Booth step: conditional add/subtract, then an arithmetic shift right
    // of {A, Q, q_m1}.
    logic [AW-1:0]      m_sext;
    logic [AW-1:0]      a_sum;
    logic [AW-1:0]      a_next;
    logic [EW-1:0]      q_next;
    logic               q_m1_next;
    logic [2*WIDTH-1:0] prod_next;

    assign m_sext = {m_reg[EW-1], m_reg};

    always_comb begin
        a_sum = a_reg;
        case ({q_reg[0], q_m1_reg})
            2'b01:   a_sum = a_reg + m_sext;
            2'b10:   a_sum = a_reg - m_sext;
            default: a_sum = a_reg;
        endcase
    end

    assign a_next    = {a_sum[AW-1], a_sum[AW-1:1]};
    assign q_next    = {a_sum[0], q_reg[EW-1:1]};
    assign q_m1_next = q_reg[0];
    // Low 2*WIDTH bits of {A, Q} after the shift: all of Q plus the low
    // WIDTH-1 bits of A.
    assign prod_next = {a_next[WIDTH-2:0], q_next};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            m_reg         <= '0;
            q_reg         <= '0;
            a_reg         <= '0;
            q_m1_reg      <= 1'b0;
            cnt_reg       <= '0;
            prod_reg      <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (in_valid) begin
                        m_reg        <= a_ext;
                        q_reg        <= b_ext;
                        a_reg        <= '0;
                        q_m1_reg     <= 1'b0;
                        cnt_reg      <= CW'(WIDTH);
                        state_reg    <= S_CALC;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end
                S_CALC: begin
                    a_reg    <= a_next;
                    q_reg    <= q_next;
                    q_m1_reg <= q_m1_next;
                    cnt_reg  <= cnt_reg - CW'(1);
                    // Counter runs WIDTH..0, giving WIDTH+1 steps in total.
                    if (cnt_reg == '0) begin
                        prod_reg      <= prod_next;
                        out_valid_reg <= 1'b1;
                        state_reg     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= S_IDLE;
                    end
                end
                default: begin
                    state_reg     <= S_IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_reg;
    assign out_valid   = out_valid_reg;
    assign out_product = prod_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq
//   Self-checking bench for booth_mult_seq at WIDTH=4 and WIDTH=8. Expected
//   products come from plain integer multiplication of the extended operands.
module tb_booth_mult_seq;

    logic        clk;
    logic        rst;
    int          cyc;
    int          total;
    int          passed;

    logic        iv4, ir4, is4, ov4, or4, busy4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;

    logic        iv8, ir8, is8, ov8, or8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    booth_mult_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(iv4), .in_ready(ir4), .in_signed(is4),
        .in_a(a4), .in_b(b4),
        .out_valid(ov4), .out_ready(or4), .out_product(p4), .busy(busy4)
    );

    booth_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(iv8), .in_ready(ir8), .in_signed(is8),
        .in_a(a8), .in_b(b8),
        .out_valid(ov8), .out_ready(or8), .out_product(p8), .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: interpret operands as integers per mode, multiply, keep 2w bits.
    function automatic logic [63:0] model(int w, bit s, logic [63:0] a, logic [63:0] b);
        longint one;
        longint ea;
        longint eb;
        longint pr;
        one = 1;
        ea  = longint'(a);
        eb  = longint'(b);
        if (s && a[w-1]) ea = ea - (one << w);
        if (s && b[w-1]) eb = eb - (one << w);
        pr = ea * eb;
        return 64'(pr & ((one << (2 * w)) - 1));
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One WIDTH=4 transaction with `hold` cycles of backpressure.
    task automatic op4(bit s, logic [3:0] a, logic [3:0] b, int hold, output logic [7:0] got);
        logic [7:0] exp;
        int lat;
        exp = 8'(model(4, s, 64'(a), 64'(b)));
        @(negedge clk);
        chk("w4_in_ready_idle", 64'(ir4), 64'(1));
        is4 = s; a4 = a; b4 = b; iv4 = 1'b1;
        @(negedge clk);
        iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); is4 = ~s;
        chk("w4_busy_calc", 64'(busy4), 64'(1));
        lat = 0;
        while (!ov4 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("w4_latency", 64'(lat), 64'(5));
        chk("w4_product", 64'(p4), 64'(exp));
        for (int i = 0; i < hold; i++) begin
            iv4 = 1'b1; a4 = 4'($urandom); b4 = 4'($urandom);
            @(negedge clk);
            chk("w4_hold_valid", 64'(ov4), 64'(1));
            chk("w4_hold_product", 64'(p4), 64'(exp));
            chk("w4_hold_in_ready", 64'(ir4), 64'(0));
        end
        iv4 = 1'b0;
        got = p4;
        or4 = 1'b1;
        @(negedge clk);
        or4 = 1'b0;
        chk("w4_release_valid", 64'(ov4), 64'(0));
        chk("w4_release_busy", 64'(busy4), 64'(0));
        chk("w4_release_kept", 64'(p4), 64'(exp));
        $display("w4 op s=%0d a=%h b=%h hold=%0d product=%h", s, a, b, hold, got);
    endtask

    task automatic op8(bit s, logic [7:0] a, logic [7:0] b, output logic [15:0] got);
        logic [15:0] exp;
        int lat;
        exp = 16'(model(8, s, 64'(a), 64'(b)));
        @(negedge clk);
        chk("w8_in_ready_idle", 64'(ir8), 64'(1));
        is8 = s; a8 = a; b8 = b; iv8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); is8 = ~s;
        lat = 0;
        while (!ov8 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("w8_latency", 64'(lat), 64'(9));
        chk("w8_product", 64'(p8), 64'(exp));
        got = p8;
        or8 = 1'b1;
        @(negedge clk);
        or8 = 1'b0;
        chk("w8_release_valid", 64'(ov8), 64'(0));
        $display("w8 op s=%0d a=%h b=%h product=%h", s, a, b, got);
    endtask

    initial begin
        logic [7:0]  g4;
        logic [15:0] g8;
        logic [7:0]  ta [3];
        logic [7:0]  tb [3];
        bit          ts [3];
        int          acc [3];
        int          n;
        int          stray;

        total = 0; passed = 0;
        rst = 1'b1;
        iv4 = 0; is4 = 0; a4 = 0; b4 = 0; or4 = 0;
        iv8 = 0; is8 = 0; a8 = 0; b8 = 0; or8 = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_in_ready4", 64'(ir4), 64'(1));
        chk("reset_out_valid4", 64'(ov4), 64'(0));
        chk("reset_busy4", 64'(busy4), 64'(0));
        chk("reset_product4", 64'(p4), 64'(0));
        chk("reset_in_ready8", 64'(ir8), 64'(1));
        chk("reset_product8", 64'(p8), 64'(0));

        // Directed WIDTH=4 cases.
        op4(1'b1, 4'h8, 4'h8, 0, g4); chk("s_m8_m8", 64'(g4), 64'h40);
        op4(1'b1, 4'h7, 4'h8, 0, g4); chk("s_7_m8", 64'(g4), 64'hC8);
        op4(1'b1, 4'hF, 4'hF, 0, g4); chk("s_m1_m1", 64'(g4), 64'h01);
        op4(1'b1, 4'h0, 4'h8, 0, g4); chk("s_0_m8", 64'(g4), 64'h00);
        op4(1'b0, 4'hF, 4'hF, 0, g4); chk("u_15_15", 64'(g4), 64'hE1);
        op4(1'b1, 4'hF, 4'hF, 3, g4); chk("s_15_15_bp", 64'(g4), 64'h01);

        // Reset after two CALC cycles aborts the operation.
        @(negedge clk);
        is4 = 1'b0; a4 = 4'd9; b4 = 4'd13; iv4 = 1'b1;
        @(negedge clk);
        iv4 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1; or4 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", 64'(ir4), 64'(1));
        chk("abort_out_valid", 64'(ov4), 64'(0));
        chk("abort_busy", 64'(busy4), 64'(0));
        chk("abort_product", 64'(p4), 64'(0));
        stray = 0;
        repeat (10) begin
            @(negedge clk);
            if (ov4) stray++;
        end
        or4 = 1'b0;
        chk("abort_no_result", 64'(stray), 64'(0));
        op4(1'b0, 4'd3, 4'd5, 0, g4); chk("u_3_5_after_reset", 64'(g4), 64'h0F);

        // Randomised WIDTH=4 traffic.
        for (int i = 0; i < 20; i++) begin
            op4(1'($urandom), 4'($urandom), 4'($urandom), int'($urandom_range(0, 2)), g4);
        end

        // Directed WIDTH=8 cases.
        op8(1'b0, 8'hFF, 8'hFF, g8); chk("u_255_255", 64'(g8), 64'hFE01);
        op8(1'b1, 8'h80, 8'h80, g8); chk("s_m128_m128", 64'(g8), 64'h4000);
        op8(1'b1, 8'h7F, 8'h80, g8); chk("s_127_m128", 64'(g8), 64'hC080);
        for (int i = 0; i < 10; i++) begin
            op8(1'($urandom), 8'($urandom), 8'($urandom), g8);
        end

        // Back-to-back WIDTH=8 with in_valid and out_ready held high.
        ta[0] = 8'd200; tb[0] = 8'd17;  ts[0] = 1'b0;
        ta[1] = 8'h80;  tb[1] = 8'h7F;  ts[1] = 1'b1;
        ta[2] = 8'd255; tb[2] = 8'd254; ts[2] = 1'b0;
        or8 = 1'b1;
        is8 = ts[0]; a8 = ta[0]; b8 = tb[0]; iv8 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!ir8 && n < 60) begin
                @(negedge clk);
                n++;
            end
            acc[k] = cyc;
            @(negedge clk);
            if (k < 2) begin
                is8 = ts[k+1]; a8 = ta[k+1]; b8 = tb[k+1];
            end else begin
                iv8 = 1'b0;
            end
            n = 0;
            while (!ov8 && n < 60) begin
                @(negedge clk);
                n++;
            end
            chk("b2b_product", 64'(p8), model(8, ts[k], 64'(ta[k]), 64'(tb[k])));
            if (k > 0) chk("b2b_spacing", 64'(acc[k] - acc[k-1]), 64'(11));
            $display("w8 b2b op s=%0d a=%h b=%h product=%h", ts[k], ta[k], tb[k], p8);
        end
        @(negedge clk);
        or8 = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
